// File: rtl/btn_debounce_shot_pkg.sv
// btn_debounce_shot_pkg: shared defaults and button index constants for the push-button front end
package btn_debounce_shot_pkg;
    localparam int NUM_BTN_DEF         = 3;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int BTN_FLOOR1          = 0;
    localparam int BTN_FLOOR2          = 1;
    localparam int BTN_SPARE           = 2;
endpackage

// File: rtl/btn_debounce_bit.sv
// btn_debounce_bit: one button channel - polarity, 2-flop synchroniser, debounce counter, stable level and press shot
module btn_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic shot
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic s1, s2;
    logic [CW-1:0] cnt;
    logic done;
    assign done = (s2 != stable) && (cnt == CNT_MAX);
    // bring the pin into the clock domain with pressed always reading as 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw ^ ACTIVE_LOW;
            s2 <= s1;
        end
    end
    // accept a new level only after it has persisted for the full window; shot marks accepted presses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
            shot   <= 1'b0;
        end else begin
            shot <= done && s2;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (done) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/btn_debounce_shot.sv
// btn_debounce_shot: independent debounce and press-pulse channel per elevator button
module btn_debounce_shot
    import btn_debounce_shot_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_stable,
    output logic [NUM_BTN-1:0] btn_stable_shot
);
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .stable(btn_stable[i]),
            .shot  (btn_stable_shot[i])
        );
    end
endmodule

// File: tb/tb_btn_debounce_shot.sv
// tb_btn_debounce_shot: directed plan plus random bounce traffic against a history-window reference model
module tb_btn_debounce_shot;
    localparam int NB = 3;
    localparam int D  = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] st0, sh0, st1, sh1;
    int n_vec = 0;
    int n_err = 0;
    logic run_chk = 1'b0;
    always #5 clk = ~clk;

    btn_debounce_shot #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_stable(st0), .btn_stable_shot(sh0));
    btn_debounce_shot #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .btn_raw(~btn_raw), .btn_stable(st1), .btn_stable_shot(sh1));

    task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // reference: a level flips once the last D synchronised samples all disagree with it
    logic [NB-1:0] m_stable = '0;
    logic [NB-1:0] m_shot = '0;
    logic [D:0] hist [NB];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_stable = '0;
            m_shot = '0;
            for (int c = 0; c < NB; c++) hist[c] = '0;
        end else begin
            for (int c = 0; c < NB; c++) begin
                logic ad;
                ad = 1'b1;
                for (int j = 1; j <= D; j++) if (hist[c][j] == m_stable[c]) ad = 1'b0;
                m_shot[c] = ad && !m_stable[c];
                if (ad) m_stable[c] = ~m_stable[c];
                hist[c] = {hist[c][D-1:0], btn_raw[c]};
            end
        end
    end

    always @(negedge clk) begin
        if (run_chk && !rst) begin
            chk("stable", st0, m_stable);
            chk("shot", sh0, m_shot);
            chk("stable_al", st1, m_stable);
            chk("shot_al", sh1, m_shot);
        end
    end

    task automatic press_check(input logic [NB-1:0] val, input logic [NB-1:0] shot_exp, input string tag);
        @(negedge clk) btn_raw = val;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 chk({tag, "_early"}, sh0 | sh1, '0);
        @(posedge clk);
        #1 chk({tag, "_shot"}, sh0, shot_exp);
        chk({tag, "_shot_al"}, sh1, shot_exp);
        @(posedge clk);
        #1 chk({tag, "_drop"}, sh0 | sh1, '0);
    endtask

    task automatic async_reset;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_stable", st0 | st1, '0);
        chk("rst_shot", sh0 | sh1, '0);
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk("rst_hold", st0 | sh0 | st1 | sh1, '0);
        @(negedge clk) rst = 1'b0;
        run_chk = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle", st0 | sh0 | st1 | sh1, '0);
        async_reset();
        repeat (5) @(negedge clk);
        press_check(3'b001, 3'b001, "clean");
        repeat (14) @(negedge clk);
        chk("clean_hold", st0, 3'b001);
        for (int p = 0; p < 4; p++) begin
            @(negedge clk) btn_raw[1] = (p % 2 == 0);
            repeat (2) @(negedge clk);
        end
        press_check(3'b011, 3'b010, "bounce");
        repeat (8) @(negedge clk);
        @(negedge clk) btn_raw = 3'b010;
        repeat (10) @(negedge clk);
        chk("release", st0, 3'b010);
        press_check(3'b011, 3'b001, "repress");
        repeat (8) @(negedge clk);
        @(negedge clk) btn_raw = '0;
        repeat (12) @(negedge clk);
        chk("all_released", st0, '0);
        press_check(3'b011, 3'b011, "simul");
        repeat (8) @(negedge clk);
        @(negedge clk) btn_raw = 3'b111;
        @(posedge clk);
        @(posedge clk);
        async_reset();
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 chk("rst_mid_early", sh0 | sh1, '0);
        @(posedge clk);
        #1 chk("rst_mid_shot", sh0, 3'b111);
        chk("rst_mid_shot_al", sh1, 3'b111);
        repeat (10) @(negedge clk);
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            for (int c = 0; c < NB; c++) if ($urandom_range(5) == 0) btn_raw[c] = ~btn_raw[c];
            if ($urandom_range(199) == 0) async_reset();
        end
        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
